cpu_phase_sequencer: RTL and testbench

//  Parametrised multicycle control sequencer for the MIPS core; replaces the single-bit

---
 rtl/cpu_seq_pkg.sv | 23 ++
 rtl/seq_watchdog.sv | 31 +++
 rtl/cpu_phase_sequencer.sv | 166 ++++++++++++++++
 tb/tb_cpu_phase_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and default vectors for the multicycle phase sequencer.
package cpu_seq_pkg;

    localparam int unsigned SEQ_ST_W = 3;

    typedef enum logic [SEQ_ST_W-1:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4,
        HALT  = 3'd5
    } seq_state_t;

    localparam logic [31:0] SEQ_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] SEQ_ISR_VEC   = 32'h0000_0000;

    // True for the states that own an outstanding memory request.
    function automatic logic seq_is_mem_state(input seq_state_t s);
        return (s == FETCH) || (s == MEM);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Memory-wait watchdog: counts consecutive unanswered request cycles and
// flags expiry on the TO_CYCLES-th one. Only built when SEQ_TIMEOUT_EN is set.
module seq_watchdog
    import cpu_seq_pkg::*;
#(
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_wait,
    output logic o_expire_c
);

    localparam int unsigned CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign o_expire_c = i_wait && (r_cnt == CNT_W'(TO_CYCLES - 1));

    // Count waiting cycles; any ack or idle cycle restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_wait && !o_expire_c) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multicycle fetch/exec/mem/writeback sequencer owning PC, IR and load data.
// Optional feature: define SEQ_TIMEOUT_EN to enable the memory watchdog / HALT.
module cpu_phase_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned     DATA_W    = 32,
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(SEQ_RESET_VEC),
    parameter logic [PC_W-1:0] ISR_VEC   = PC_W'(SEQ_ISR_VEC),
    parameter int unsigned     TO_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    output logic              mem_req,
    output logic              mem_we,
    output logic [PC_W-3:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [PC_W-1:0]   pc,
    input  logic [PC_W-1:0]   next_pc,
    input  logic [PC_W-1:0]   epc,
    input  logic              eret,
    input  logic              jisr,
    input  logic [PC_W-1:0]   ea,
    input  logic              do_load,
    input  logic              do_store,
    output logic [DATA_W-1:0] load_data,
    output logic              gp_we_en,
    output logic              exec_phase,
    output logic              abort
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic              w_pc_upd;
    logic [PC_W-3:0]   r_mem_addr;
    logic [PC_W-3:0]   w_addr_nxt;
    logic              w_we_nxt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_is_load;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_load_data;
    logic              r_gp_we;
    logic              r_exec;
    logic              r_abort;
    logic              w_ack;
    logic              w_wd_expire;
    logic              w_unused;

    // Acks only count while a request is actually outstanding.
    assign w_ack = mem_ack && r_mem_req;

`ifdef SEQ_TIMEOUT_EN
    seq_watchdog #(
        .TO_CYCLES (TO_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .i_wait     (r_mem_req && !mem_ack),
        .o_expire_c (w_wd_expire)
    );
    assign w_unused = ^ea[1:0];
`else
    logic [31:0] w_to_unused;
    assign w_to_unused = 32'(TO_CYCLES);
    assign w_wd_expire = 1'b0;
    assign w_unused    = ^{ea[1:0], w_to_unused};
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, PC redirect and next request address/direction.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_upd    = 1'b0;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_mem_addr;
        w_we_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (ena) begin
                    w_state_nxt = FETCH;
                    w_addr_nxt  = r_pc[PC_W-1:2];
                end
            end
            FETCH: begin
                if (w_ack) w_state_nxt = EXEC;
            end
            EXEC: begin
                if (do_load || do_store) begin
                    w_state_nxt = MEM;
                    w_addr_nxt  = ea[PC_W-1:2];
                end else begin
                    w_state_nxt = WB;
                end
            end
            MEM: begin
                if (w_ack) w_state_nxt = WB;
            end
            WB: begin
                w_pc_upd = 1'b1;
                w_pc_nxt = jisr ? ISR_VEC : (eret ? epc : next_pc);
                if (ena) begin
                    w_state_nxt = FETCH;
                    w_addr_nxt  = w_pc_nxt[PC_W-1:2];
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
        endcase
        if (w_wd_expire) w_state_nxt = HALT;
        if (w_state_nxt == MEM) w_we_nxt = (r_state == MEM) ? r_mem_we : do_store;
    end

    // Registered outputs and datapath captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_VEC;
            r_mem_addr  <= RESET_VEC[PC_W-1:2];
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_is_load   <= 1'b0;
            r_instr     <= '0;
            r_load_data <= '0;
            r_gp_we     <= 1'b0;
            r_exec      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_mem_req  <= seq_is_mem_state(w_state_nxt);
            r_mem_we   <= w_we_nxt;
            r_mem_addr <= w_addr_nxt;
            r_gp_we    <= (w_state_nxt == WB);
            r_exec     <= (w_state_nxt == EXEC) || (w_state_nxt == MEM) || (w_state_nxt == WB);
            r_abort    <= (w_state_nxt == HALT);
            if (w_pc_upd) r_pc <= w_pc_nxt;
            if (r_state == FETCH && w_ack) r_instr <= mem_rdata;
            if (r_state == EXEC) r_is_load <= do_load;
            if (r_state == MEM && w_ack && r_is_load) r_load_data <= mem_rdata;
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign instr      = r_instr;
    assign pc         = r_pc;
    assign load_data  = r_load_data;
    assign gp_we_en   = r_gp_we;
    assign exec_phase = r_exec;
    assign abort      = r_abort;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Randomised bench: each instruction is planned up front (kind, wait states,
// targets) and the expected per-cycle outputs are derived from that plan.
module tb_cpu_phase_sequencer;

    localparam logic [31:0] RST_V = 32'h0000_0000;
    localparam logic [31:0] ISR_V = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] epc;
    logic        eret;
    logic        jisr;
    logic [31:0] ea;
    logic        do_load;
    logic        do_store;
    logic [31:0] load_data;
    logic        gp_we_en;
    logic        exec_phase;
    logic        abort;

    cpu_phase_sequencer #(
        .DATA_W    (32),
        .PC_W      (32),
        .RESET_VEC (RST_V),
        .ISR_VEC   (ISR_V),
        .TO_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .pc         (pc),
        .next_pc    (next_pc),
        .epc        (epc),
        .eret       (eret),
        .jisr       (jisr),
        .ea         (ea),
        .do_load    (do_load),
        .do_store   (do_store),
        .load_data  (load_data),
        .gp_we_en   (gp_we_en),
        .exec_phase (exec_phase),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [29:0] addr;
        logic        gp;
        logic        ex;
        logic        ab;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] ld;
    } exp_t;

    int   n_pass = 0;
    int   n_tot  = 0;
    exp_t cur_exp;
    logic exp_valid = 1'b0;

    // Architectural model state
    logic [31:0] m_pc, m_instr, m_ld;
    logic        m_run;

    int          r_kind, r_fw, r_mw;
    logic [31:0] r_nxt;
    logic        r_ji, r_er, r_cont;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tot++;
        if (act !== want)
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
        else
            n_pass++;
    endtask

    function automatic exp_t mk_exp(input logic req, input logic we, input logic [29:0] a,
                                    input logic gp, input logic ex, input logic ab);
        exp_t e;
        e.req = req; e.we = we; e.addr = a; e.gp = gp; e.ex = ex; e.ab = ab;
        e.pc = m_pc; e.ir = m_instr; e.ld = m_ld;
        return e;
    endfunction

    // Per-cycle comparison against the planned expectation.
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("mem_req",    32'(mem_req),    32'(cur_exp.req));
            chk("mem_we",     32'(mem_we),     32'(cur_exp.we));
            chk("gp_we_en",   32'(gp_we_en),   32'(cur_exp.gp));
            chk("exec_phase", 32'(exec_phase), 32'(cur_exp.ex));
            chk("abort",      32'(abort),      32'(cur_exp.ab));
            chk("pc",         pc,              cur_exp.pc);
            chk("instr",      instr,           cur_exp.ir);
            chk("load_data",  load_data,       cur_exp.ld);
            if (cur_exp.req) chk("mem_addr", 32'(mem_addr), 32'(cur_exp.addr));
        end
    end

    // Start a cycle: randomise don't-care inputs, publish the expectation.
    task automatic begin_slot(input exp_t e);
        @(posedge clk);
        #1;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        jisr      = 1'($urandom_range(0, 1));
        eret      = 1'($urandom_range(0, 1));
        epc       = $urandom;
        next_pc   = $urandom;
        do_load   = 1'($urandom_range(0, 1));
        do_store  = 1'($urandom_range(0, 1));
        ea        = $urandom;
        cur_exp   = e;
        exp_valid = 1'b1;
    endtask

    task automatic idle_slots(input int n, input logic en);
        for (int i = 0; i < n; i++) begin
            begin_slot(mk_exp(1'b0, 1'b0, 30'd0, 1'b0, 1'b0, 1'b0));
            ena = en;
        end
    endtask

    // One instruction: kind 0=ALU 1=load 2=store; fw/mw = wait cycles before ack.
    task automatic run_instr(input int kind, input int fw, input int mw,
                             input logic [31:0] ea_v, input logic [31:0] ri,
                             input logic [31:0] rd, input logic [31:0] nxt,
                             input logic ji, input logic er, input logic [31:0] ep,
                             input logic cont);
        if (!m_run) idle_slots(1, 1'b1);
        for (int i = 0; i <= fw; i++) begin
            begin_slot(mk_exp(1'b1, 1'b0, m_pc[31:2], 1'b0, 1'b0, 1'b0));
            ena = cont;
            mem_ack = (i == fw);
            mem_rdata = ri;
        end
        m_instr = ri;
        begin_slot(mk_exp(1'b0, 1'b0, 30'd0, 1'b0, 1'b1, 1'b0));
        ena = cont; do_load = (kind == 1); do_store = (kind == 2); ea = ea_v;
        if (kind != 0) begin
            for (int j = 0; j <= mw; j++) begin
                begin_slot(mk_exp(1'b1, kind == 2, ea_v[31:2], 1'b0, 1'b1, 1'b0));
                ena = cont; do_load = (kind == 1); do_store = (kind == 2); ea = ea_v;
                mem_ack = (j == mw);
                mem_rdata = rd;
            end
            if (kind == 1) m_ld = rd;
        end
        begin_slot(mk_exp(1'b0, 1'b0, 30'd0, 1'b1, 1'b1, 1'b0));
        ena = cont; do_load = (kind == 1); do_store = (kind == 2); ea = ea_v;
        jisr = ji; eret = er; epc = ep; next_pc = nxt;
        m_pc  = ji ? ISR_V : (er ? ep : nxt);
        m_run = cont;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; mem_ack = 1'b0; mem_rdata = '0; next_pc = '0; epc = '0;
        eret = 1'b0; jisr = 1'b0; ea = '0; do_load = 1'b0; do_store = 1'b0;
        m_pc = RST_V; m_instr = '0; m_ld = '0; m_run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_pc", pc, RST_V);
        chk("rst_instr", instr, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_gp_we", 32'(gp_we_en), 32'd0);
        chk("rst_exec", 32'(exec_phase), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        rst = 1'b0;

        // Warm-up load so registers hold non-reset values, then reset mid-fetch.
        run_instr(1, 1, 1, 32'h300, 32'h8C00_0000, 32'h1234_5678, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_slots(1, 1'b1);
        begin_slot(mk_exp(1'b1, 1'b0, m_pc[31:2], 1'b0, 1'b0, 1'b0));
        ena = 1'b0; mem_ack = 1'b0;
        chk("pre_rst_pc", pc, 32'h40);
        #2;
        exp_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_fetch_req", 32'(mem_req), 32'd0);
        chk("rst_mid_fetch_pc", pc, RST_V);
        chk("rst_mid_fetch_instr", instr, 32'd0);
        chk("rst_mid_fetch_ld", load_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; ena = 1'b0;
        m_pc = RST_V; m_instr = '0; m_ld = '0; m_run = 1'b0;

        // ALU op, zero-wait fetch
        run_instr(0, 0, 0, 32'h0, 32'h0022_1820, 32'h0, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_slots(1, 1'b0);
        chk("alu_pc", pc, 32'h4);

        // Load with five wait states at ea 0x100
        run_instr(1, 0, 5, 32'h100, 32'h8C01_0100, 32'hDEAD_BEEF, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_slots(1, 1'b0);
        chk("load_data", load_data, 32'hDEAD_BEEF);
        chk("load_pc", pc, 32'h8);

        // jisr beats eret, then eret alone
        run_instr(0, 0, 0, 32'h0, 32'h4200_0018, 32'h0, 32'hC, 1'b1, 1'b1, 32'h80, 1'b0);
        idle_slots(1, 1'b0);
        chk("jisr_pc", pc, ISR_V);
        run_instr(0, 1, 0, 32'h0, 32'h4200_0018, 32'h0, 32'h184, 1'b0, 1'b1, 32'h80, 1'b0);
        idle_slots(1, 1'b0);
        chk("eret_pc", pc, 32'h80);

        // Store with ena low throughout: completes, then stops in IDLE
        run_instr(2, 1, 2, 32'h207, 32'hAC02_0207, 32'h0, 32'h84, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_slots(2, 1'b0);
        chk("stop_pc", pc, 32'h84);
        chk("stop_req", 32'(mem_req), 32'd0);
        chk("stop_exec", 32'(exec_phase), 32'd0);

        // PC wraps modulo 2^32
        run_instr(0, 0, 0, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1);
        run_instr(0, 0, 0, 32'h0, 32'h2, 32'h0, m_pc + 32'd4, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_slots(1, 1'b0);
        chk("wrap_pc", pc, 32'h0);

        // Randomised instruction stream
        for (int k = 0; k < 200; k++) begin
            r_kind = int'($urandom_range(0, 2));
            r_fw   = int'($urandom_range(0, 6));
            r_mw   = int'($urandom_range(0, 6));
            r_nxt  = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
            r_ji   = ($urandom_range(0, 7) == 0);
            r_er   = ($urandom_range(0, 5) == 0);
            r_cont = ($urandom_range(0, 3) != 0);
            if (!m_run && $urandom_range(0, 1) == 1) idle_slots(int'($urandom_range(1, 3)), 1'b0);
            run_instr(r_kind, r_fw, r_mw, $urandom, $urandom, $urandom, r_nxt,
                      r_ji, r_er, $urandom, r_cont);
        end
        if (m_run) run_instr(0, 0, 0, 32'h0, 32'h3, 32'h0, m_pc + 32'd4, 1'b0, 1'b0, 32'h0, 1'b0);

`ifdef SEQ_TIMEOUT_EN
        // Fetch never acknowledged: eight request cycles, then HALT with abort
        idle_slots(1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            begin_slot(mk_exp(1'b1, 1'b0, m_pc[31:2], 1'b0, 1'b0, 1'b0));
            ena = 1'b1; mem_ack = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            begin_slot(mk_exp(1'b0, 1'b0, 30'd0, 1'b0, 1'b0, 1'b1));
            ena = 1'b1;
        end
        chk("halt_abort", 32'(abort), 32'd1);
        chk("halt_req", 32'(mem_req), 32'd0);
`endif

        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
